// File: rtl/ip_tile_host_pkg.sv
// Shared types and constants for the ip_tile host sequencer.
// The response bundle widths follow the default tile register sizes.
package ip_tile_host_pkg;

    localparam int STATUS_W = 16;
    localparam int DATA_W   = 32;
    localparam int CNT_W    = 16;
    localparam int GO_BIT   = 15;
    localparam int DONE_BIT = 15;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    typedef struct packed {
        logic [STATUS_W-1:0] status;
        logic [DATA_W-1:0]   data;
        logic                timeout;
    } rsp_t;

endpackage

// File: rtl/ip_tile_host_timer.sv
// Loadable saturating down-counter shared by the setup and timeout counts.
// Terminal count is high whenever the count has reached zero.
module ip_tile_host_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_value,
    output logic         tc
);

    logic [W-1:0] count;

    // Reload on request, otherwise count down and stick at zero
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (en && count != '0) begin
            count <= count - W'(1);
        end
    end

    assign tc = (count == '0);

endmodule

// File: rtl/ip_tile_host_sequencer.sv
// Host-side initiator: loads operands into a tile, pulses GO and
// collects the status/result or a timeout into a held response.
module ip_tile_host_sequencer
    import ip_tile_host_pkg::*;
#(
    parameter int CSR_IN_WIDTH   = 16,
    parameter int CSR_OUT_WIDTH  = STATUS_W,
    parameter int REG_WIDTH      = DATA_W,
    parameter int SETUP_CYCLES   = 1,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                     clk,
    input  logic                     arst_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [CSR_IN_WIDTH-2:0]  cmd_ctrl,
    input  logic [REG_WIDTH-1:0]     cmd_a,
    input  logic [REG_WIDTH-1:0]     cmd_b,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [CSR_OUT_WIDTH-1:0] rsp_status,
    output logic [REG_WIDTH-1:0]     rsp_data,
    output logic                     rsp_timeout,
    output logic [CSR_IN_WIDTH-1:0]  csr_in,
    input  logic                     csr_in_re,
    output logic [REG_WIDTH-1:0]     data_reg_a,
    output logic [REG_WIDTH-1:0]     data_reg_b,
    input  logic [CSR_OUT_WIDTH-1:0] csr_out,
    input  logic                     csr_out_we,
    input  logic [REG_WIDTH-1:0]     data_reg_c,
    output logic                     busy,
    output logic                     spurious_we
);

    localparam logic [CNT_W-1:0] SETUP_LOAD   = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t                  state;
    state_t                  state_nxt;
    logic [CSR_IN_WIDTH-1:0] csr_in_q;
    logic [REG_WIDTH-1:0]    reg_a_q;
    logic [REG_WIDTH-1:0]    reg_b_q;
    rsp_t                    rsp_q;
    logic                    spurious_q;
    logic                    tc;
    logic                    active;
    logic                    done_evt;
    logic                    finish_ok;
    logic                    time_out;
    logic                    accept;
    logic                    go_now;

    assign active    = (state == ISSUE) || (state == WAIT);
    assign done_evt  = csr_out_we && csr_out[DONE_BIT];
    assign finish_ok = ((state == ISSUE) && csr_in_re && done_evt) ||
                       ((state == WAIT) && done_evt);
    assign time_out  = active && tc && !finish_ok;
    assign accept    = (state == IDLE) && cmd_valid;
    assign go_now    = (state == SETUP) && tc;

    ip_tile_host_timer #(.W(CNT_W)) u_timer (
        .clk        (clk),
        .rst_n      (arst_n),
        .load       (accept || go_now),
        .en         ((state == SETUP) || active),
        .load_value ((state == IDLE) ? SETUP_LOAD : TIMEOUT_LOAD),
        .tc         (tc)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; a DONE beats a timeout in the same cycle
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (cmd_valid) state_nxt = SETUP;
            SETUP: if (tc) state_nxt = ISSUE;
            ISSUE: begin
                if (finish_ok || time_out) state_nxt = RESP;
                else if (csr_in_re)        state_nxt = WAIT;
            end
            WAIT:  if (finish_ok || time_out) state_nxt = RESP;
            RESP:  if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand, CSR and response capture
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            csr_in_q   <= '0;
            reg_a_q    <= '0;
            reg_b_q    <= '0;
            rsp_q      <= '0;
            spurious_q <= 1'b0;
        end else begin
            if (accept) begin
                csr_in_q <= {1'b0, cmd_ctrl};
                reg_a_q  <= cmd_a;
                reg_b_q  <= cmd_b;
            end
            if (go_now) csr_in_q[GO_BIT] <= 1'b1;
            if ((state == ISSUE) && (csr_in_re || tc)) csr_in_q[GO_BIT] <= 1'b0;
            if (active && csr_out_we) rsp_q.status <= csr_out;
            if (finish_ok) rsp_q.data <= data_reg_c;
            if (time_out) begin
                rsp_q.data    <= '0;
                rsp_q.timeout <= 1'b1;
            end
            if ((state == RESP) && rsp_ready) begin
                csr_in_q      <= '0;
                reg_a_q       <= '0;
                reg_b_q       <= '0;
                rsp_q.timeout <= 1'b0;
            end
            if (csr_out_we && !active) spurious_q <= 1'b1;
        end
    end

    // Outputs decoded from registered state and datapath
    always_comb begin
        cmd_ready   = (state == IDLE);
        busy        = (state != IDLE);
        rsp_valid   = (state == RESP);
        rsp_status  = rsp_q.status;
        rsp_data    = rsp_q.data;
        rsp_timeout = rsp_q.timeout;
        csr_in      = csr_in_q;
        data_reg_a  = reg_a_q;
        data_reg_b  = reg_b_q;
        spurious_we = spurious_q;
    end

endmodule

// File: tb/tb_ip_tile_host_sequencer.sv
// Directed bench for ip_tile_host_sequencer with a scripted tile.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_ip_tile_host_sequencer;

    logic        clk = 1'b0;
    logic        arst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [14:0] cmd_ctrl;
    logic [31:0] cmd_a;
    logic [31:0] cmd_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_status;
    logic [31:0] rsp_data;
    logic        rsp_timeout;
    logic [15:0] csr_in;
    logic        csr_in_re;
    logic [31:0] data_reg_a;
    logic [31:0] data_reg_b;
    logic [15:0] csr_out;
    logic        csr_out_we;
    logic [31:0] data_reg_c;
    logic        busy;
    logic        spurious_we;

    int errors = 0;
    int checks = 0;

    ip_tile_host_sequencer #(
        .SETUP_CYCLES   (1),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk         (clk),
        .arst_n      (arst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_ctrl    (cmd_ctrl),
        .cmd_a       (cmd_a),
        .cmd_b       (cmd_b),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_status  (rsp_status),
        .rsp_data    (rsp_data),
        .rsp_timeout (rsp_timeout),
        .csr_in      (csr_in),
        .csr_in_re   (csr_in_re),
        .data_reg_a  (data_reg_a),
        .data_reg_b  (data_reg_b),
        .csr_out     (csr_out),
        .csr_out_we  (csr_out_we),
        .data_reg_c  (data_reg_c),
        .busy        (busy),
        .spurious_we (spurious_we)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        arst_n = 1'b0; cmd_valid = 1'b0; cmd_ctrl = '0; cmd_a = '0; cmd_b = '0;
        rsp_ready = 1'b0; csr_in_re = 1'b0; csr_out = '0; csr_out_we = 1'b0;
        data_reg_c = '0;
        tick(); tick();
        arst_n = 1'b1;
        checks++;
        if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready); end
        checks++;
        if ({busy, rsp_valid, rsp_timeout, spurious_we} !== 4'b0) begin
            errors++; $display("FAIL reset_flags got=%b exp=0000", {busy, rsp_valid, rsp_timeout, spurious_we});
        end
        checks++;
        if ({csr_in, data_reg_a, data_reg_b, rsp_status, rsp_data} !== '0) begin
            errors++; $display("FAIL reset_regs csr_in=%h a=%h b=%h st=%h d=%h exp=0", csr_in, data_reg_a, data_reg_b, rsp_status, rsp_data);
        end
    endtask

    task automatic test_nominal();
        int go_cycles = 0;
        cmd_valid = 1'b1; cmd_a = 32'hA5A5A5A5; cmd_b = 32'h12A2A3A5; cmd_ctrl = 15'h01F5;
        tick();
        cmd_valid = 1'b0;
        checks++;
        if ({cmd_ready, busy} !== 2'b01) begin errors++; $display("FAIL nom_setup_flags got=%b exp=01", {cmd_ready, busy}); end
        checks++;
        if (data_reg_a !== 32'hA5A5A5A5 || data_reg_b !== 32'h12A2A3A5 || csr_in !== 16'h01F5) begin
            errors++; $display("FAIL nom_setup_regs a=%h b=%h csr_in=%h exp=a5a5a5a5 12a2a3a5 01f5", data_reg_a, data_reg_b, csr_in);
        end
        for (int c = 0; c < 8; c++) begin
            tick();
            if (csr_in === 16'h81F5) go_cycles++;
            csr_in_re  = (c == 2);
            csr_out_we = (c == 7);
            csr_out    = (c == 7) ? 16'h8003 : 16'h0000;
            data_reg_c = (c == 7) ? 32'h5A5A5A5A : 32'h0;
            if (c == 3) begin
                checks++;
                if (csr_in !== 16'h01F5 || busy !== 1'b1) begin
                    errors++; $display("FAIL nom_wait_csr got=%h busy=%b exp=01f5 1", csr_in, busy);
                end
            end
        end
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL nom_early_rsp got=%b exp=0", rsp_valid); end
        tick();
        csr_out_we = 1'b0;
        checks++;
        if (go_cycles !== 3) begin errors++; $display("FAIL nom_go_len got=%0d exp=3", go_cycles); end
        checks++;
        if (rsp_valid !== 1'b1 || rsp_status !== 16'h8003 || rsp_data !== 32'h5A5A5A5A || rsp_timeout !== 1'b0) begin
            errors++; $display("FAIL nom_rsp v=%b st=%h d=%h to=%b exp=1 8003 5a5a5a5a 0", rsp_valid, rsp_status, rsp_data, rsp_timeout);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checks++;
        if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || csr_in !== 16'h0 || data_reg_a !== 32'h0 || data_reg_b !== 32'h0) begin
            errors++; $display("FAIL nom_release rdy=%b v=%b csr_in=%h a=%h b=%h exp=1 0 0 0 0", cmd_ready, rsp_valid, csr_in, data_reg_a, data_reg_b);
        end
    endtask

    task automatic test_timeout();
        int go_cycles = 0;
        cmd_valid = 1'b1; cmd_a = 32'h0BADCAFE; cmd_b = 32'h00000001; cmd_ctrl = 15'h0010;
        tick();
        cmd_valid = 1'b0;
        for (int c = 0; c < 16; c++) begin
            tick();
            if (csr_in[15] === 1'b1) go_cycles++;
        end
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL to_early_rsp got=%b exp=0", rsp_valid); end
        tick();
        checks++;
        if (go_cycles !== 16) begin errors++; $display("FAIL to_go_len got=%0d exp=16", go_cycles); end
        checks++;
        if (rsp_valid !== 1'b1 || csr_in[15] !== 1'b0 || rsp_timeout !== 1'b1 || rsp_data !== 32'h0 || rsp_status !== 16'h8003) begin
            errors++; $display("FAIL to_rsp v=%b go=%b to=%b d=%h st=%h exp=1 0 1 0 8003", rsp_valid, csr_in[15], rsp_timeout, rsp_data, rsp_status);
        end
    endtask

    task automatic test_backpressure();
        int bad = 0;
        cmd_valid = 1'b1; cmd_a = 32'h11112222; cmd_b = 32'h33334444; cmd_ctrl = 15'h0042;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (rsp_valid !== 1'b1 || rsp_timeout !== 1'b1 || rsp_data !== 32'h0 || rsp_status !== 16'h8003 ||
                cmd_ready !== 1'b0 || data_reg_a !== 32'h0BADCAFE) bad++;
        end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL bp_hold bad_cycles=%0d exp=0", bad); end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checks++;
        if (busy !== 1'b0 || cmd_ready !== 1'b1 || data_reg_a !== 32'h0 || csr_in !== 16'h0 || rsp_timeout !== 1'b0) begin
            errors++; $display("FAIL bp_no_accept busy=%b rdy=%b a=%h csr_in=%h to=%b exp=0 1 0 0 0", busy, cmd_ready, data_reg_a, csr_in, rsp_timeout);
        end
        tick();
        cmd_valid = 1'b0;
        checks++;
        if (busy !== 1'b1 || data_reg_a !== 32'h11112222 || data_reg_b !== 32'h33334444) begin
            errors++; $display("FAIL bp_accept busy=%b a=%h b=%h exp=1 11112222 33334444", busy, data_reg_a, data_reg_b);
        end
    endtask

    task automatic test_simultaneous();
        tick();
        checks++;
        if (csr_in !== 16'h8042) begin errors++; $display("FAIL sim_go got=%h exp=8042", csr_in); end
        csr_in_re = 1'b1; csr_out_we = 1'b1; csr_out = 16'h8000; data_reg_c = 32'hCAFEF00D;
        tick();
        csr_in_re = 1'b0; csr_out_we = 1'b0;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_status !== 16'h8000 || rsp_data !== 32'hCAFEF00D || rsp_timeout !== 1'b0 || csr_in[15] !== 1'b0) begin
            errors++; $display("FAIL sim_rsp v=%b st=%h d=%h to=%b go=%b exp=1 8000 cafef00d 0 0", rsp_valid, rsp_status, rsp_data, rsp_timeout, csr_in[15]);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_progress_spurious();
        cmd_valid = 1'b1; cmd_a = 32'h1; cmd_b = 32'h2; cmd_ctrl = 15'h0007;
        tick();
        cmd_valid = 1'b0;
        tick();
        csr_in_re = 1'b1;
        tick();
        csr_in_re = 1'b0;
        csr_out_we = 1'b1; csr_out = 16'h0001; data_reg_c = 32'hDEAD0000;
        tick();
        csr_out_we = 1'b0;
        checks++;
        if (busy !== 1'b1 || rsp_valid !== 1'b0 || rsp_status !== 16'h0001 || rsp_data !== 32'hCAFEF00D) begin
            errors++; $display("FAIL prog_wait busy=%b v=%b st=%h d=%h exp=1 0 0001 cafef00d", busy, rsp_valid, rsp_status, rsp_data);
        end
        csr_out_we = 1'b1; csr_out = 16'h8055; data_reg_c = 32'h600DF00D;
        tick();
        csr_out_we = 1'b0;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_status !== 16'h8055 || rsp_data !== 32'h600DF00D) begin
            errors++; $display("FAIL prog_done v=%b st=%h d=%h exp=1 8055 600df00d", rsp_valid, rsp_status, rsp_data);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checks++;
        if (spurious_we !== 1'b0) begin errors++; $display("FAIL spur_pre got=%b exp=0", spurious_we); end
        csr_out_we = 1'b1; csr_out = 16'h8FFF; data_reg_c = 32'hFFFFFFFF;
        tick();
        csr_out_we = 1'b0;
        checks++;
        if (spurious_we !== 1'b1 || busy !== 1'b0 || rsp_status !== 16'h8055 || rsp_data !== 32'h600DF00D) begin
            errors++; $display("FAIL spur_post sp=%b busy=%b st=%h d=%h exp=1 0 8055 600df00d", spurious_we, busy, rsp_status, rsp_data);
        end
    endtask

    task automatic test_reset_mid();
        cmd_valid = 1'b1; cmd_a = 32'h77777777; cmd_b = 32'h88888888; cmd_ctrl = 15'h0123;
        tick();
        cmd_valid = 1'b0;
        tick();
        csr_in_re = 1'b1;
        tick();
        csr_in_re = 1'b0;
        checks++;
        if (busy !== 1'b1 || csr_in !== 16'h0123) begin errors++; $display("FAIL rst_pre busy=%b csr_in=%h exp=1 0123", busy, csr_in); end
        arst_n = 1'b0;
        tick();
        arst_n = 1'b1;
        checks++;
        if (csr_in !== 16'h0 || busy !== 1'b0 || cmd_ready !== 1'b1 || spurious_we !== 1'b0 || data_reg_a !== 32'h0 || rsp_valid !== 1'b0) begin
            errors++; $display("FAIL rst_mid csr_in=%h busy=%b rdy=%b sp=%b a=%h v=%b exp=0 0 1 0 0 0", csr_in, busy, cmd_ready, spurious_we, data_reg_a, rsp_valid);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_timeout();
        test_backpressure();
        test_simultaneous();
        test_progress_spurious();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
